// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register offsets, CTRL layout and helpers for apb_timer
package apb_timer_pkg;
  localparam logic [3:0] CTRL   = 4'h0;
  localparam logic [3:0] LOAD   = 4'h4;
  localparam logic [3:0] VALUE  = 4'h8;
  localparam logic [3:0] STATUS = 4'hC;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_IE       = 2;
  localparam int PRESCALE_LSB  = 8;
  localparam int PRESCALE_MSB  = 15;
  typedef struct packed {
    logic [7:0] prescale;
    logic       ie;
    logic       oneshot;
    logic       en;
  } ctrl_t;
  // Byte-lane merge of write data into an existing register value
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  // CTRL as seen on the bus; unused bits read 0
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] r;
    r = '0;
    r[CTRL_EN] = c.en;
    r[CTRL_ONESHOT] = c.oneshot;
    r[CTRL_IE] = c.ie;
    r[PRESCALE_MSB:PRESCALE_LSB] = c.prescale;
    return r;
  endfunction
endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: 8-bit divider producing a tick when the count reaches prescale
module apb_timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] prescale,
  input  logic       clr,
  output logic       tick
);
  logic [7:0] cnt;
  assign tick = en & (cnt == prescale);
  // Count while enabled, restart on tick or explicit clear, freeze otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB down-counting timer with prescaler, one-shot mode and sticky interrupt
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [3:0]                PSTRB,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      timer_irq_o,
  output logic                      timer_pulse_o
);
  ctrl_t       ctrl, ctrl_wr;
  logic [31:0] load, value, rdata;
  logic [3:0]  off;
  logic        irq_flag, tick, expire, access, err, wr, wr_ctrl, en_rise;
  assign off     = PADDR[3:0];
  assign access  = PSEL & PENABLE;
  assign err     = (PADDR[APB_ADDR_WIDTH-1:4] != '0) | (PADDR[1:0] != 2'b00) | (PWRITE & (off == VALUE));
  assign wr      = access & PWRITE & ~err;
  assign wr_ctrl = wr & (off == CTRL);
  assign en_rise = wr_ctrl & ctrl_wr.en & ~ctrl.en;
  assign expire  = tick & (value == 32'd0);
  // CTRL image after a strobed write
  always_comb begin
    ctrl_wr.en       = PSTRB[0] ? PWDATA[CTRL_EN] : ctrl.en;
    ctrl_wr.oneshot  = PSTRB[0] ? PWDATA[CTRL_ONESHOT] : ctrl.oneshot;
    ctrl_wr.ie       = PSTRB[0] ? PWDATA[CTRL_IE] : ctrl.ie;
    ctrl_wr.prescale = PSTRB[1] ? PWDATA[PRESCALE_MSB:PRESCALE_LSB] : ctrl.prescale;
  end
  // Read mux and zero-wait-state response; data and error only in the access phase
  always_comb begin
    rdata   = off == CTRL ? ctrl_word(ctrl) : off == LOAD ? load : off == VALUE ? value : {31'b0, irq_flag};
    PRDATA  = (access & ~PWRITE & ~err) ? rdata : '0;
    PREADY  = access;
    PSLVERR = access & err;
  end
  assign timer_irq_o   = irq_flag & ctrl.ie;
  assign timer_pulse_o = expire;
  apb_timer_prescaler u_prescaler (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .en       (ctrl.en),
    .prescale (ctrl.prescale),
    .clr      (en_rise),
    .tick     (tick)
  );
  // CTRL: bus write wins over the one-shot auto-disable
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) ctrl <= '0;
    else if (wr_ctrl) ctrl <= ctrl_wr;
    else if (expire && ctrl.oneshot) ctrl.en <= 1'b0;
  // LOAD register, byte-strobed
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) load <= '0;
    else if (wr && off == LOAD) load <= strb_merge(load, PWDATA, PSTRB);
  // Main counter: start on enable, reload or hold 0 on expiry, otherwise decrement per tick
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) value <= '0;
    else if (en_rise) value <= load;
    else if (expire) value <= ctrl.oneshot ? 32'd0 : load;
    else if (tick) value <= value - 32'd1;
  // Sticky interrupt flag; expiry beats a same-cycle write-1-to-clear
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) irq_flag <= 1'b0;
    else if (expire) irq_flag <= 1'b1;
    else if (wr && off == STATUS && PSTRB[0] && PWDATA[0]) irq_flag <= 1'b0;
endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed self-checking bench for apb_timer
module tb_apb_timer;
  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, timer_irq_o, timer_pulse_o;
  int          n_chk = 0, n_err = 0;
  logic [31:0] d, pv, iv;
  logic        e, r;

  apb_timer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .timer_irq_o(timer_irq_o), .timer_pulse_o(timer_pulse_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] s, output logic err);
    PADDR = a; PWDATA = wd; PSTRB = s; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] rd, output logic err, output logic rdy);
    PADDR = a; PWRITE = 1'b0; PSTRB = '0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #1 rd = PRDATA; err = PSLVERR; rdy = PREADY;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic run(input int n, output logic [31:0] p, output logic [31:0] q);
    p = '0; q = '0;
    for (int c = 0; c < n; c++) begin
      p[c] = timer_pulse_o; q[c] = timer_irq_o;
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_irq", {31'b0, timer_irq_o}, 0);
    check("rst_pulse", {31'b0, timer_pulse_o}, 0);
    check("rst_idle_bus", {PRDATA[30:0], PREADY, PSLVERR}, 0);
    #4 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 4; i++) begin
      apb_read(12'(4 * i), d, e, r);
      check("rst_rd_data", d, 0);
      check("rst_rd_err_rdy", {30'b0, e, r}, 32'b01);
    end

    apb_write(12'h004, 32'd3, 4'hF, e);
    apb_write(12'h000, 32'h5, 4'hF, e);
    run(12, pv, iv);
    check("per_pulses", pv, 32'h888);
    check("per_irq", iv, 32'hFF0);
    apb_read(12'h00C, d, e, r);
    check("per_status", d, 1);
    apb_write(12'h000, 32'h4, 4'hF, e);
    apb_write(12'h00C, 32'h1, 4'hF, e);
    check("w1c_irq", {31'b0, timer_irq_o}, 0);
    apb_read(12'h00C, d, e, r);
    check("w1c_status", d, 0);

    apb_write(12'h000, 32'h5, 4'hF, e);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    apb_write(12'h00C, 32'h1, 4'hF, e);
    apb_read(12'h00C, d, e, r);
    check("w1c_vs_expiry", d, 1);
    apb_write(12'h000, 32'h0, 4'hF, e);
    apb_write(12'h00C, 32'h1, 4'hF, e);

    apb_write(12'h004, 32'd1, 4'hF, e);
    apb_write(12'h000, 32'h203, 4'hF, e);
    run(12, pv, iv);
    check("os_pulses", pv, 32'h20);
    check("os_irq", iv, 0);
    apb_read(12'h000, d, e, r);
    check("os_ctrl", d, 32'h202);
    apb_read(12'h008, d, e, r);
    check("os_value", d, 0);
    apb_read(12'h00C, d, e, r);
    check("os_status", d, 1);

    apb_write(12'h008, 32'h1234, 4'hF, e);
    check("err_wr_value", {31'b0, e}, 1);
    apb_write(12'h014, 32'hDEAD, 4'hF, e);
    check("err_wr_alias", {31'b0, e}, 1);
    apb_read(12'h004, d, e, r);
    check("err_load_kept", d, 1);
    apb_read(12'h010, d, e, r);
    check("err_rd_10", {d[30:0], e}, 1);
    apb_read(12'h006, d, e, r);
    check("err_rd_06", {d[30:0], e}, 1);
    apb_read(12'h008, d, e, r);
    check("err_value_kept", d, 0);

    apb_write(12'h004, 32'h0, 4'hF, e);
    apb_write(12'h004, 32'hFFFF_FFFF, 4'b0001, e);
    apb_read(12'h004, d, e, r);
    check("strb_lane0", d, 32'h0000_00FF);
    apb_write(12'h004, 32'hFFFF_FFFF, 4'b0000, e);
    apb_read(12'h004, d, e, r);
    check("strb_none", d, 32'h0000_00FF);
    apb_write(12'h004, 32'hFFFF_FFFF, 4'b0100, e);
    apb_read(12'h004, d, e, r);
    check("strb_lane2", d, 32'h00FF_00FF);

    apb_write(12'h00C, 32'h1, 4'hF, e);
    apb_write(12'h004, 32'd3, 4'hF, e);
    apb_write(12'h000, 32'h5, 4'hF, e);
    run(6, pv, iv);
    check("pre_rst_irq", {31'b0, timer_irq_o}, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("arst_irq_pulse", {30'b0, timer_irq_o, timer_pulse_o}, 0);
    check("arst_bus", {PRDATA[30:0], PREADY, PSLVERR}, 0);
    #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apb_read(12'h000, d, e, r);
    check("arst_ctrl", d, 0);
    apb_read(12'h004, d, e, r);
    check("arst_load", d, 0);
    apb_read(12'h008, d, e, r);
    check("arst_value", d, 0);
    apb_read(12'h00C, d, e, r);
    check("arst_status", d, 0);
    run(8, pv, iv);
    check("arst_no_pulse", pv | iv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
